ula_seq_driver: RTL and testbench

- Hardware stimulus sequencer that acts as the operator side of the projeto_ula_fsm user interface.
- Given operands and an opcode, it drives sw_entrada and the active-low botao_prox through one complete ALU transaction: reset, load A, load B, load OP, execute.
- After each press it checks the FSM state on leds_debug, then captures the result flags.
- Used on-board for self-test and in benches as a synthesizable replacement for manual key presses.

---
 rtl/ula_pkg.sv | 40 ++++
 rtl/ula_seq_driver_if.sv | 22 ++
 rtl/ula_press_gen.sv | 62 ++++++
 rtl/ula_seq_driver.sv | 179 +++++++++++++++++
 tb/tb_ula_seq_driver.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the projeto_ula_fsm operator-side sequencer:
// ALU FSM state encodings, opcodes, error codes and driver state enums.
package ula_pkg;

  localparam logic [2:0] ST_RESET   = 3'd0;
  localparam logic [2:0] ST_LOAD_A  = 3'd1;
  localparam logic [2:0] ST_LOAD_B  = 3'd2;
  localparam logic [2:0] ST_LOAD_OP = 3'd3;
  localparam logic [2:0] ST_EXEC    = 3'd4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_SYNC    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    DRV_IDLE,
    DRV_SYNC,
    DRV_SETUP,
    DRV_PRESS,
    DRV_RELEASE,
    DRV_CHECK,
    DRV_EXEC,
    DRV_FINISH
  } drv_state_t;

  typedef enum logic [1:0] {
    PG_IDLE,
    PG_HOLD,
    PG_GAP
  } pg_state_t;

  // ALU state that a press on the given step should produce.
  function automatic logic [2:0] expected_led(input logic [1:0] step);
    return {1'b0, step} + 3'd1;
  endfunction

endpackage

// File: rtl/ula_seq_driver_if.sv
// Request/response bus of the sequencer: operands and opcode in,
// busy/done handshake plus captured result out.
interface ula_seq_driver_if;
  logic       start;
  logic [2:0] a_in;
  logic [2:0] b_in;
  logic [2:0] op_in;
  logic       busy;
  logic       done;
  logic [1:0] err_code;
  logic [2:0] flags_out;

  modport master (
    output start, a_in, b_in, op_in,
    input  busy, done, err_code, flags_out
  );

  modport slave (
    input  start, a_in, b_in, op_in,
    output busy, done, err_code, flags_out
  );
endinterface

// File: rtl/ula_press_gen.sv
// Single key-press generator: one go pulse yields one registered low pulse
// of HOLD_CYCLES on botao_prox, then GAP_CYCLES high, then press_done.
module ula_press_gen
  import ula_pkg::*;
#(
  parameter int HOLD_CYCLES = 5,
  parameter int GAP_CYCLES  = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  output logic botao_prox,
  output logic press_done
);

  localparam int MAX_W = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  pg_state_t        state;
  logic [CNT_W-1:0] cnt;

  // Press timing FSM; botao_prox comes straight from a flop so it cannot glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PG_IDLE;
      cnt        <= '0;
      botao_prox <= 1'b1;
      press_done <= 1'b0;
    end else begin
      press_done <= 1'b0;
      case (state)
        PG_IDLE: begin
          if (go) begin
            botao_prox <= 1'b0;
            cnt        <= CNT_W'(HOLD_CYCLES - 1);
            state      <= PG_HOLD;
          end
        end
        PG_HOLD: begin
          if (cnt == '0) begin
            botao_prox <= 1'b1;
            cnt        <= CNT_W'(GAP_CYCLES - 1);
            state      <= PG_GAP;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        PG_GAP: begin
          if (cnt == '0) begin
            press_done <= 1'b1;
            state      <= PG_IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: state <= PG_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ula_seq_driver.sv
// Operator-side sequencer for projeto_ula_fsm: syncs the ALU FSM to state 0,
// loads A, B and OP with one key press each, checks leds_debug after every
// press and captures {over, zero, neg} once the ALU reaches execute.
module ula_seq_driver
  import ula_pkg::*;
#(
  parameter int HOLD_CYCLES    = 5,
  parameter int GAP_CYCLES     = 5,
  parameter int SETUP_CYCLES   = 3,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_SYNC       = 5
) (
  input  logic              clk,
  input  logic              rst,
  ula_seq_driver_if.slave   req,
  input  logic [2:0]        leds_debug,
  input  logic              led_over,
  input  logic              led_zero,
  input  logic              led_neg,
  output logic [2:0]        sw_entrada,
  output logic              botao_prox
);

  localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_HGS = (MAX_HG > SETUP_CYCLES) ? MAX_HG : SETUP_CYCLES;
  localparam int MAX_ALL = (MAX_HGS > TIMEOUT_CYCLES) ? MAX_HGS : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);
  localparam int SYNC_W  = $clog2(MAX_SYNC + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [SYNC_W-1:0] SYNC_ONE = SYNC_W'(1);

  drv_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [SYNC_W-1:0] sync_cnt;
  logic [1:0]        step;
  logic              sync_press;
  logic [2:0]        a_q, b_q, op_q;
  logic              busy_r, done_r;
  logic [1:0]        err_r;
  logic [2:0]        flags_r;
  logic              go;
  logic              press_done;
  logic              pg_botao;

  // Switch value presented to the ALU for each load step.
  function automatic logic [2:0] step_value(input logic [1:0] s, input logic [2:0] a,
                                            input logic [2:0] b, input logic [2:0] op);
    case (s)
      2'd0:    step_value = 3'b000;
      2'd1:    step_value = a;
      2'd2:    step_value = b;
      default: step_value = op;
    endcase
  endfunction

  assign req.busy      = busy_r;
  assign req.done      = done_r;
  assign req.err_code  = err_r;
  assign req.flags_out = flags_r;
  assign botao_prox    = pg_botao;

  // Press request fires on the same edge the FSM moves into PRESS.
  always_comb begin
    go = 1'b0;
    if (state == DRV_SETUP && cnt == '0) go = 1'b1;
    if (state == DRV_SYNC && leds_debug != ST_RESET && sync_cnt != SYNC_W'(MAX_SYNC)) go = 1'b1;
  end

  ula_press_gen #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES)
  ) u_press (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .botao_prox (pg_botao),
    .press_done (press_done)
  );

  // Transaction sequencer: sync, per-step setup/press/check, execute, finish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DRV_IDLE;
      cnt        <= '0;
      sync_cnt   <= '0;
      step       <= '0;
      sync_press <= 1'b0;
      sw_entrada <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= ERR_OK;
      flags_r    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        DRV_IDLE: begin
          if (req.start) begin
            a_q      <= req.a_in;
            b_q      <= req.b_in;
            op_q     <= req.op_in;
            busy_r   <= 1'b1;
            err_r    <= ERR_OK;
            sync_cnt <= '0;
            state    <= DRV_SYNC;
          end
        end
        DRV_SYNC: begin
          if (leds_debug == ST_RESET) begin
            step       <= 2'd0;
            sync_press <= 1'b0;
            sw_entrada <= step_value(2'd0, a_q, b_q, op_q);
            cnt        <= CNT_W'(SETUP_CYCLES - 1);
            state      <= DRV_SETUP;
          end else if (sync_cnt == SYNC_W'(MAX_SYNC)) begin
            err_r  <= ERR_SYNC;
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= DRV_FINISH;
          end else begin
            sync_cnt   <= sync_cnt + SYNC_ONE;
            sync_press <= 1'b1;
            state      <= DRV_PRESS;
          end
        end
        DRV_SETUP: begin
          if (cnt == '0) state <= DRV_PRESS;
          else           cnt   <= cnt - CNT_ONE;
        end
        DRV_PRESS: begin
          if (pg_botao) state <= DRV_RELEASE;
        end
        DRV_RELEASE: begin
          if (press_done) begin
            if (sync_press) begin
              state <= DRV_SYNC;
            end else begin
              cnt   <= CNT_W'(TIMEOUT_CYCLES - 1);
              state <= DRV_CHECK;
            end
          end
        end
        DRV_CHECK: begin
          if (leds_debug == expected_led(step)) begin
            if (step == 2'd3) begin
              cnt   <= CNT_ONE;
              state <= DRV_EXEC;
            end else begin
              step       <= step + 2'd1;
              sw_entrada <= step_value(step + 2'd1, a_q, b_q, op_q);
              cnt        <= CNT_W'(SETUP_CYCLES - 1);
              state      <= DRV_SETUP;
            end
          end else if (cnt == '0) begin
            err_r  <= ERR_TIMEOUT;
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= DRV_FINISH;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        DRV_EXEC: begin
          if (cnt == '0) begin
            flags_r <= {led_over, led_zero, led_neg};
            err_r   <= ERR_OK;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state   <= DRV_FINISH;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        DRV_FINISH: state <= DRV_IDLE;
        default:    state <= DRV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq_driver.sv
// Bench for ula_seq_driver: a behavioural projeto_ula_fsm (with stuck-state
// stub modes), a press scoreboard and a transaction scoreboard.
module tb_ula_seq_driver;
  import ula_pkg::*;

  localparam int HOLD_CYCLES    = 5;
  localparam int GAP_CYCLES     = 5;
  localparam int SETUP_CYCLES   = 3;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int MAX_SYNC       = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] leds_debug;
  logic       led_over, led_zero, led_neg;
  logic [2:0] sw_entrada;
  logic       botao_prox;

  ula_seq_driver_if bus ();

  ula_seq_driver #(
    .HOLD_CYCLES    (HOLD_CYCLES),
    .GAP_CYCLES     (GAP_CYCLES),
    .SETUP_CYCLES   (SETUP_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .MAX_SYNC       (MAX_SYNC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (bus),
    .leds_debug (leds_debug),
    .led_over   (led_over),
    .led_zero   (led_zero),
    .led_neg    (led_neg),
    .sw_entrada (sw_entrada),
    .botao_prox (botao_prox)
  );

  always #10 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  // ---------------- ALU model (mode 0 real, 1 stuck at 1, 2 stuck at 2) -----
  int         mode      = 0;
  logic       model_clr = 1'b1;
  logic [2:0] alu_st = 3'd0, ra = 3'd0, rb = 3'd0, rop = 3'd0;
  logic       botao_q = 1'b1;
  logic [3:0] alu_res;

  always @(posedge clk) begin
    botao_q <= botao_prox;
    if (model_clr) alu_st <= ST_RESET;
    else if (botao_q && !botao_prox) begin
      case (alu_st)
        ST_RESET:   alu_st <= ST_LOAD_A;
        ST_LOAD_A:  begin ra  <= sw_entrada; alu_st <= ST_LOAD_B;  end
        ST_LOAD_B:  begin rb  <= sw_entrada; alu_st <= ST_LOAD_OP; end
        ST_LOAD_OP: begin rop <= sw_entrada; alu_st <= ST_EXEC;    end
        default:    alu_st <= ST_RESET;
      endcase
    end
  end

  always_comb begin
    alu_res    = (rop == OP_SUB) ? ({1'b0, ra} - {1'b0, rb}) : ({1'b0, ra} + {1'b0, rb});
    led_over   = 1'b0;
    led_zero   = (alu_res == 4'd0);
    led_neg    = alu_res[3];
    leds_debug = alu_st;
    if (mode == 1) leds_debug = (alu_st == ST_RESET) ? ST_RESET : ST_LOAD_A;
    if (mode == 2) leds_debug = ST_LOAD_B;
  end

  // ---------------- scoreboards ---------------------------------------------
  typedef struct {
    logic [1:0] err;
    logic [2:0] flags;
    int         presses;
    int         lat;
  } txn_t;

  txn_t       exp_q[$];
  logic [2:0] sw_q[$];

  task automatic expect_txn(input logic [1:0] err, input logic [2:0] flags,
                            input int presses, input int lat);
    txn_t t;
    t.err = err; t.flags = flags; t.presses = presses; t.lat = lat;
    exp_q.push_back(t);
  endtask

  task automatic expect_sw(input logic [2:0] v);
    sw_q.push_back(v);
  endtask

  // ---------------- monitor -------------------------------------------------
  int         cyc = 0;
  logic       botao_prev = 1'b1;
  logic       in_press = 1'b0, aborted = 1'b0;
  int         low_w = 0, stab = 0, press_cnt = 0, last_rise = 0, done_cnt = 0;
  logic [2:0] sw_prev = 3'd0, sw_fall = 3'd0, exp_sw;
  txn_t       got;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      press_cnt = 0;
      if (in_press) aborted = 1'b1;
    end
    if (botao_prev && !botao_prox) begin
      press_cnt++;
      in_press = 1'b1;
      aborted  = rst;
      low_w    = 1;
      chk("press_expected", sw_q.size() != 0, 1);
      if (sw_q.size() != 0) begin
        exp_sw = sw_q.pop_front();
        chk("press_sw", sw_entrada, exp_sw);
      end
      chk("sw_setup_stable", stab >= SETUP_CYCLES, 1);
      sw_fall = sw_entrada;
    end else if (!botao_prev && !botao_prox) begin
      low_w++;
    end else if (!botao_prev && botao_prox) begin
      last_rise = cyc;
      in_press  = 1'b0;
      if (!aborted) begin
        chk("press_width", low_w, HOLD_CYCLES);
        chk("sw_hold", sw_entrada, sw_fall);
      end
    end
    stab       = (sw_entrada == sw_prev) ? stab + 1 : 1;
    sw_prev    = sw_entrada;
    botao_prev = botao_prox;

    if (bus.done === 1'b1) begin
      done_cnt++;
      chk("done_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        got = exp_q.pop_front();
        chk("err_code", bus.err_code, got.err);
        chk("flags_out", bus.flags_out, got.flags);
        chk("press_count", press_cnt, got.presses);
        if (got.lat >= 0) chk("timeout_latency", cyc - last_rise, got.lat);
      end
      press_cnt = 0;
    end
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("busy_drops", bus.busy, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_txn(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op);
    @(negedge clk);
    bus.start = 1'b1; bus.a_in = a; bus.b_in = b; bus.op_in = op;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
  endtask

  task automatic clear_model(input int m);
    @(negedge clk); model_clr = 1'b1; mode = m;
    @(negedge clk); model_clr = 1'b0;
  endtask

  initial begin
    int n;
    int done_before;
    bus.start = 1'b0; bus.a_in = '0; bus.b_in = '0; bus.op_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_sw", sw_entrada, 0);
    chk("rst_botao", botao_prox, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err_code, ERR_OK);
    chk("rst_flags", bus.flags_out, 0);
    rst = 1'b0; model_clr = 1'b0;

    // 3 + 1 from a fresh ALU: no sync press, result 4
    expect_sw(3'd0); expect_sw(3'd3); expect_sw(3'd1); expect_sw(OP_ADD);
    expect_txn(ERR_OK, 3'b000, 4, -1);
    run_txn(3'd3, 3'd1, OP_ADD);

    // 2 - 5 from state 4: one sync press carrying the old OP, result -3
    expect_sw(OP_ADD);
    expect_sw(3'd0); expect_sw(3'd2); expect_sw(3'd5); expect_sw(OP_SUB);
    expect_txn(ERR_OK, 3'b001, 5, -1);
    run_txn(3'd2, 3'd5, OP_SUB);

    // 5 - 5: zero flag
    expect_sw(OP_SUB);
    expect_sw(3'd0); expect_sw(3'd5); expect_sw(3'd5); expect_sw(OP_SUB);
    expect_txn(ERR_OK, 3'b010, 5, -1);
    run_txn(3'd5, 3'd5, OP_SUB);

    // ALU display stuck at 1: timeout in the check after the second press
    clear_model(1);
    expect_sw(3'd0); expect_sw(3'd6);
    expect_txn(ERR_TIMEOUT, 3'b010, 2, GAP_CYCLES + 1 + TIMEOUT_CYCLES);
    run_txn(3'd6, 3'd3, OP_ADD);

    // ALU display stuck at 2: sync gives up after MAX_SYNC presses
    mode = 2;
    for (int i = 0; i < MAX_SYNC; i++) expect_sw(3'd6);
    expect_txn(ERR_SYNC, 3'b010, 5, -1);
    run_txn(3'd7, 3'd1, OP_ADD);

    // reset in the middle of a press
    clear_model(0);
    expect_sw(3'd0);
    @(negedge clk);
    bus.start = 1'b1; bus.a_in = 3'd1; bus.b_in = 3'd1; bus.op_in = OP_ADD;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (botao_prox && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("press_reached", botao_prox, 0);
    chk("busy_mid_press", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_botao", botao_prox, 1);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_sw", sw_entrada, 0);
    chk("midrst_err", bus.err_code, ERR_OK);
    chk("midrst_flags", bus.flags_out, 0);
    @(negedge clk);
    rst = 1'b0;

    // start held high while busy, operands changed mid-transaction
    clear_model(0);
    expect_sw(3'd0); expect_sw(3'd1); expect_sw(3'd2); expect_sw(OP_ADD);
    expect_txn(ERR_OK, 3'b000, 4, -1);
    done_before = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.a_in = 3'd1; bus.b_in = 3'd2; bus.op_in = OP_ADD;
    repeat (3) @(negedge clk);
    bus.a_in = 3'd7; bus.b_in = 3'd6; bus.op_in = OP_SUB;
    repeat (7) @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);
    chk("single_done", done_cnt - done_before, 1);

    chk("press_queue_drained", sw_q.size(), 0);
    chk("txn_queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
